// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single external memory port.
// Data access wins by default; a saturating starvation counter guarantees fetch progress.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              resetn_i,

    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [XLEN-1:0]   dm_addr_i,
    input  logic [XLEN-1:0]   dm_wdata_i,
    input  logic [XLEN/8-1:0] dm_be_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [XLEN-1:0]   dm_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_be_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,

    output logic              err_o
);

    localparam int BW = XLEN / 8;
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    state_e          state_q;
    logic            owner_dm_q;
    logic [3:0]      starve_q;
    logic [3:0]      starve_d;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [BW-1:0]   mem_be_q;
    logic            err_q;
    logic            err_d;
    logic            pick_dm_d;
    logic            gnt_hit_d;
    logic            rsp_hit_d;

    // Arbitration decision, handshake qualification and sticky error next value.
    always_comb begin
        pick_dm_d = dm_req_i && !(if_req_i && (starve_q == LIMIT_C));
        gnt_hit_d = (state_q == S_REQ) && mem_gnt_i;
        rsp_hit_d = (state_q == S_RSP) && mem_rvalid_i;
        err_d     = err_q
                  | (mem_rvalid_i && (state_q != S_RSP))
                  | (mem_gnt_i    && (state_q != S_REQ));
    end

    // Starvation counter: counts data grants taken while a fetch waits.
    always_comb begin
        starve_d = starve_q;
        case (state_q)
            S_IDLE: begin
                if (!if_req_i) begin
                    starve_d = 4'd0;
                end else begin
                    starve_d = starve_q;
                end
            end
            S_REQ: begin
                if (!mem_gnt_i) begin
                    starve_d = starve_q;
                end else if (!owner_dm_q) begin
                    starve_d = 4'd0;
                end else if (if_req_i && (starve_q < LIMIT_C)) begin
                    starve_d = starve_q + 4'd1;
                end else begin
                    starve_d = starve_q;
                end
            end
            default: starve_d = starve_q;
        endcase
    end

    // Transaction FSM with registered memory-side request fields.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b0;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            starve_q <= starve_d;
            err_q    <= err_d;
            case (state_q)
                S_IDLE: begin
                    if (dm_req_i || if_req_i) begin
                        state_q   <= S_REQ;
                        mem_req_q <= 1'b1;
                        if (pick_dm_d) begin
                            owner_dm_q  <= 1'b1;
                            mem_we_q    <= dm_we_i;
                            mem_addr_q  <= dm_addr_i;
                            mem_wdata_q <= dm_wdata_i;
                            mem_be_q    <= dm_be_i;
                        end else begin
                            owner_dm_q  <= 1'b0;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr_i;
                            mem_wdata_q <= '0;
                            mem_be_q    <= {BW{1'b1}};
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (mem_rvalid_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign err_o       = err_q;

    // Grant and response are pass-through so the owner sees them in the same cycle as memory.
    assign if_gnt_o    = gnt_hit_d && !owner_dm_q;
    assign dm_gnt_o    = gnt_hit_d &&  owner_dm_q;
    assign if_rvalid_o = rsp_hit_d && !owner_dm_q;
    assign dm_rvalid_o = rsp_hit_d &&  owner_dm_q;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int XLEN  = 32;
    localparam int BW    = XLEN / 8;
    localparam int LIMIT = 4;

    logic              clk_i;
    logic              resetn_i;
    logic              if_req_i;
    logic [XLEN-1:0]   if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [XLEN-1:0]   if_rdata_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [XLEN-1:0]   dm_addr_i;
    logic [XLEN-1:0]   dm_wdata_i;
    logic [BW-1:0]     dm_be_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [XLEN-1:0]   dm_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic [BW-1:0]     mem_be_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;
    logic              err_o;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: one outstanding transaction, owner, expected fields, starvation tally.
    bit              m_busy, m_granted, m_dm;
    logic            exp_we;
    logic [XLEN-1:0] exp_addr, exp_wdata;
    logic [BW-1:0]   exp_be;
    int              starve;
    // Requester and memory stimulus state.
    bit              if_pend, dm_pend;
    logic [XLEN-1:0] if_addr, dm_addr, dm_wdata;
    logic            dm_we;
    logic [BW-1:0]   dm_be;
    int              p_if, p_dm, p_gnt, p_rsp;
    bit              rdata_fixed;
    logic [XLEN-1:0] rdata_val;
    bit              winners[$];
    int              n_if_gnt, n_dm_gnt, n_if_rv, n_dm_rv;
    logic [XLEN-1:0] last_if_rdata;

    task automatic clear_model();
        m_busy = 1'b0; m_granted = 1'b0; m_dm = 1'b0; starve = 0;
        if_pend = 1'b0; dm_pend = 1'b0;
        winners.delete();
        n_if_gnt = 0; n_dm_gnt = 0; n_if_rv = 0; n_dm_rv = 0;
        last_if_rdata = '0;
    endtask

    task automatic drive_idle();
        if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        resetn_i = 1'b0;
        drive_idle();
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_mem_req", 32'(mem_req_o), 32'(0));
        check_val("rst_mem_fields", 32'({mem_we_o, mem_be_o}) | mem_addr_o | mem_wdata_o, 32'(0));
        check_val("rst_resp", 32'({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, err_o}) | if_rdata_o | dm_rdata_o, 32'(0));
        resetn_i = 1'b1;
    endtask

    task automatic cycle();
        bit e_req, e_ifg, e_dmg, e_ifr, e_dmr;
        @(posedge clk_i);
        #1;
        if (!if_pend && int'($urandom_range(99)) < p_if) begin
            if_pend = 1'b1; if_addr = $urandom;
        end
        if (!dm_pend && int'($urandom_range(99)) < p_dm) begin
            dm_pend = 1'b1; dm_we = 1'($urandom_range(1)); dm_addr = $urandom;
            dm_wdata = $urandom; dm_be = BW'($urandom);
        end
        if_req_i = if_pend; if_addr_i = if_addr;
        dm_req_i = dm_pend; dm_we_i = dm_we; dm_addr_i = dm_addr;
        dm_wdata_i = dm_wdata; dm_be_i = dm_be;
        mem_gnt_i    = m_busy && !m_granted && (int'($urandom_range(99)) < p_gnt);
        mem_rvalid_i = m_busy &&  m_granted && (int'($urandom_range(99)) < p_rsp);
        mem_rdata_i  = rdata_fixed ? rdata_val : $urandom;
        #1;
        e_req = m_busy && !m_granted;
        e_ifg = e_req && !m_dm && mem_gnt_i;
        e_dmg = e_req &&  m_dm && mem_gnt_i;
        e_ifr = m_busy && m_granted && !m_dm && mem_rvalid_i;
        e_dmr = m_busy && m_granted &&  m_dm && mem_rvalid_i;
        check_val("mem_req", 32'(mem_req_o), 32'(e_req));
        if (e_req) begin
            check_val("mem_addr", mem_addr_o, exp_addr);
            check_val("mem_we", 32'(mem_we_o), 32'(exp_we));
            check_val("mem_be", 32'(mem_be_o), 32'(exp_be));
            if (m_dm) check_val("mem_wdata", mem_wdata_o, exp_wdata);
        end
        check_val("if_gnt", 32'(if_gnt_o), 32'(e_ifg));
        check_val("dm_gnt", 32'(dm_gnt_o), 32'(e_dmg));
        check_val("if_rvalid", 32'(if_rvalid_o), 32'(e_ifr));
        check_val("dm_rvalid", 32'(dm_rvalid_o), 32'(e_dmr));
        check_val("if_rdata", if_rdata_o, e_ifr ? mem_rdata_i : '0);
        check_val("dm_rdata", dm_rdata_o, e_dmr ? mem_rdata_i : '0);
        check_val("err", 32'(err_o), 32'(0));
        if (if_gnt_o) n_if_gnt++;
        if (dm_gnt_o) n_dm_gnt++;
        if (dm_rvalid_o) n_dm_rv++;
        if (if_rvalid_o) begin n_if_rv++; last_if_rdata = if_rdata_o; end
        // Advance the model using this cycle's inputs.
        if (!m_busy) begin
            if (!if_req_i) starve = 0;
            if (dm_req_i || if_req_i) begin
                m_dm = dm_req_i && !(if_req_i && starve == LIMIT);
                if (m_dm) begin
                    exp_we = dm_we; exp_addr = dm_addr; exp_wdata = dm_wdata; exp_be = dm_be;
                end else begin
                    exp_we = 1'b0; exp_addr = if_addr; exp_wdata = '0; exp_be = {BW{1'b1}};
                end
                m_busy = 1'b1; m_granted = 1'b0;
                winners.push_back(m_dm);
            end
        end else if (!m_granted) begin
            if (mem_gnt_i) begin
                m_granted = 1'b1;
                if (m_dm) begin
                    dm_pend = 1'b0;
                    if (if_req_i && starve < LIMIT) starve++;
                end else begin
                    if_pend = 1'b0;
                    starve = 0;
                end
            end
        end else if (mem_rvalid_i) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic set_knobs(input int pi, input int pd, input int pg, input int pr);
        p_if = pi; p_dm = pd; p_gnt = pg; p_rsp = pr;
    endtask

    initial begin
        bit exp_order[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        rdata_fixed = 1'b0; rdata_val = '0;
        set_knobs(0, 0, 100, 100);
        do_reset();

        // Single fetch.
        rdata_fixed = 1'b1; rdata_val = 32'h0050_0093;
        if_pend = 1'b1; if_addr = 32'h0000_0100;
        repeat (5) cycle();
        check_val("fetch_gnt_pulses", 32'(n_if_gnt), 32'(1));
        check_val("fetch_rv_pulses", 32'(n_if_rv), 32'(1));
        check_val("fetch_rdata", last_if_rdata, 32'h0050_0093);
        check_val("fetch_dm_quiet", 32'(n_dm_gnt + n_dm_rv), 32'(0));
        rdata_fixed = 1'b0;

        // Simultaneous requests: data first, then fetch.
        do_reset();
        dm_pend = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000; dm_wdata = '0; dm_be = 4'hF;
        if_pend = 1'b1; if_addr = 32'h0000_0104;
        repeat (10) cycle();
        check_val("simul_count", 32'(winners.size()), 32'(2));
        if (winners.size() == 2) begin
            check_val("simul_first_dm", 32'(winners[0]), 32'(1));
            check_val("simul_second_if", 32'(winners[1]), 32'(0));
        end
        check_val("simul_rv", 32'({n_if_rv[3:0], n_dm_rv[3:0]}), 32'(8'h11));

        // Starvation with both requesters held high.
        do_reset();
        set_knobs(100, 100, 100, 100);
        for (int i = 0; i < 200 && winners.size() < 11; i++) cycle();
        check_val("starve_winners", 32'(winners.size() >= 11), 32'(1));
        for (int i = 0; i < 11; i++) begin
            if (i < winners.size()) check_val($sformatf("starve_order%0d", i), 32'(winners[i]), 32'(exp_order[i]));
        end

        // Write held off by a stalled grant.
        do_reset();
        set_knobs(0, 0, 0, 100);
        dm_pend = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_3000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
        repeat (6) cycle();
        check_val("wr_no_gnt_yet", 32'(n_dm_gnt), 32'(0));
        p_gnt = 100;
        cycle();
        check_val("wr_gnt_once", 32'(n_dm_gnt), 32'(1));
        repeat (3) cycle();
        check_val("wr_ack", 32'(n_dm_rv), 32'(1));

        // Randomized traffic.
        do_reset();
        set_knobs(40, 50, 60, 50);
        repeat (1500) cycle();
        set_knobs(0, 0, 100, 100);
        repeat (20) cycle();
        check_val("drained", 32'(m_busy), 32'(0));

        // Spurious response in IDLE.
        @(posedge clk_i); #1;
        drive_idle();
        mem_rvalid_i = 1'b1;
        #1;
        check_val("spur_no_route", 32'({if_rvalid_o, dm_rvalid_o}), 32'(0));
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        check_val("spur_err", 32'(err_o), 32'(1));
        repeat (3) @(posedge clk_i);
        #1;
        check_val("spur_err_sticky", 32'(err_o), 32'(1));

        // Reset while waiting for a response.
        do_reset();
        set_knobs(0, 0, 100, 0);
        dm_pend = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000; dm_wdata = '0; dm_be = 4'hF;
        repeat (2) cycle();
        check_val("in_rsp", 32'(m_busy && m_granted), 32'(1));
        @(posedge clk_i); #1;
        drive_idle();
        resetn_i = 1'b0;
        #1;
        check_val("arst_mem", 32'({mem_req_o, mem_we_o, mem_be_o}) | mem_addr_o, 32'(0));
        mem_rvalid_i = 1'b1;
        #1;
        check_val("arst_no_rv", 32'({dm_rvalid_o, if_rvalid_o, err_o}), 32'(0));
        mem_rvalid_i = 1'b0;
        @(posedge clk_i); #1;
        resetn_i = 1'b1;
        clear_model();
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b1;
        #1;
        check_val("late_rv_dropped", 32'({dm_rvalid_o, if_rvalid_o}), 32'(0));
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        check_val("late_rv_err", 32'(err_o), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
